// File: rtl/instruction_assembler_if.sv
// Request/write-port bundle of the instruction assembler. The loader side uses
// the master modport; the assembler uses the slave modport.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 3
`define INST_TYPE_I    3'd0
`define INST_TYPE_S    3'd1
`define INST_TYPE_SB   3'd2
`define INST_TYPE_U    3'd3
`define INST_TYPE_JAL  3'd4
`define INST_TYPE_JALR 3'd5
`endif

interface instruction_assembler_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                        addr_load;
  logic [ADDR_WIDTH-1:0]       load_addr;
  logic                        in_valid;
  logic                        in_ready;
  logic [`INST_TYPE_WIDTH-1:0] in_type;
  logic [6:0]                  in_opcode;
  logic [4:0]                  in_rd;
  logic [4:0]                  in_rs1;
  logic [4:0]                  in_rs2;
  logic [2:0]                  in_funct3;
  logic [`DATA_WIDTH-1:0]      in_imm;
  logic                        mem_we;
  logic                        mem_ready;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [`INST_WIDTH-1:0]      mem_wdata;
  logic                        err_valid;
  logic [1:0]                  err_code;
  logic [ADDR_WIDTH-1:0]       word_count;

  modport master (
    output addr_load, load_addr, in_valid, in_type, in_opcode, in_rd, in_rs1,
           in_rs2, in_funct3, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, err_valid, err_code, word_count
  );

  modport slave (
    input  addr_load, load_addr, in_valid, in_type, in_opcode, in_rd, in_rs1,
           in_rs2, in_funct3, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, err_valid, err_code, word_count
  );
endinterface

// File: rtl/instruction_assembler.sv
// Packs type/opcode/register/immediate fields into RV32 words and streams them to
// instruction memory. Define ASM_IMM_CHECK_EN to reject out-of-range immediates.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 3
`define INST_TYPE_I    3'd0
`define INST_TYPE_S    3'd1
`define INST_TYPE_SB   3'd2
`define INST_TYPE_U    3'd3
`define INST_TYPE_JAL  3'd4
`define INST_TYPE_JALR 3'd5
`endif

module instruction_assembler #(
  parameter int          ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  instruction_assembler_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_TYPE  = 2'd2
  } err_code_t;

  logic [`DATA_WIDTH-1:0] imm;
  logic [`INST_WIDTH-1:0] word;
  logic                   type_bad;
  logic                   range_bad;
  logic                   legal;
  logic                   ready;
  logic                   accept;
  logic                   write_accept;

  logic                   mem_we_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [`INST_WIDTH-1:0] mem_wdata_q;
  logic                   err_valid_q;
  err_code_t              err_code_q;
  logic [ADDR_WIDTH-1:0]  word_count_q;

  assign imm = bus.in_imm;

  always_comb begin
    // NOTE: defaults first on every path so the case below cannot infer a latch.
    word     = '0;
    type_bad = 1'b0;
    case (bus.in_type)
      `INST_TYPE_I, `INST_TYPE_JALR:
        word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      `INST_TYPE_S:
        word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
      `INST_TYPE_SB:
        word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                imm[4:1], imm[11], bus.in_opcode};
      `INST_TYPE_U:
        word = {imm[31:12], bus.in_rd, bus.in_opcode};
      `INST_TYPE_JAL:
        word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
      default:
        type_bad = 1'b1;
    endcase
  end

`ifdef ASM_IMM_CHECK_EN
  // Any immediate bit the format cannot carry makes the request illegal.
  always_comb begin
    range_bad = 1'b0;
    case (bus.in_type)
      `INST_TYPE_I, `INST_TYPE_S, `INST_TYPE_JALR: range_bad = |imm[31:12];
      `INST_TYPE_SB:                               range_bad = (|imm[31:13]) || imm[0];
      `INST_TYPE_U:                                range_bad = |imm[11:0];
      `INST_TYPE_JAL:                              range_bad = (|imm[31:21]) || imm[0];
      default:                                     range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign legal        = !type_bad && !range_bad;
  assign ready        = !mem_we_q || bus.mem_ready;
  assign accept       = bus.in_valid && ready;
  assign write_accept = mem_we_q && bus.mem_ready;

  always_ff @(posedge clk) begin
    // NOTE: rst_n is sampled only at the clock edge; glitches between edges are ignored.
    if (!rst_n) begin
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      mem_addr_q   <= BASE;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      word_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      err_valid_q <= 1'b0;
      if (accept && !legal) begin
        err_valid_q <= 1'b1;
        err_code_q  <= type_bad ? ERR_TYPE : ERR_RANGE;
      end

      // A new word replaces the one leaving on the same edge (back-to-back).
      if (accept && legal) begin
        mem_we_q    <= 1'b1;
        mem_wdata_q <= word;
      end else if (write_accept) begin
        mem_we_q <= 1'b0;
      end

      // A load wins over the increment and also retargets any pending word.
      if (bus.addr_load) begin
        mem_addr_q   <= bus.load_addr;
        word_count_q <= '0;
      end else if (write_accept) begin
        mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
        if (word_count_q != '1) word_count_q <= word_count_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_code   = err_code_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_instruction_assembler.sv
// Bench for instruction_assembler: directed steps followed by randomized traffic,
// checked against a cycle-level model that verifies words by decoding them.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 3
`define INST_TYPE_I    3'd0
`define INST_TYPE_S    3'd1
`define INST_TYPE_SB   3'd2
`define INST_TYPE_U    3'd3
`define INST_TYPE_JAL  3'd4
`define INST_TYPE_JALR 3'd5
`endif

module tb_instruction_assembler;

  localparam int AW = 4;
  localparam int N  = 1 << AW;
`ifdef ASM_IMM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int T_I    = int'(`INST_TYPE_I);
  localparam int T_S    = int'(`INST_TYPE_S);
  localparam int T_SB   = int'(`INST_TYPE_SB);
  localparam int T_U    = int'(`INST_TYPE_U);
  localparam int T_JAL  = int'(`INST_TYPE_JAL);
  localparam int T_JALR = int'(`INST_TYPE_JALR);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_assembler_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_assembler #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          ty;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
  } req_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit   m_we;
  req_t m_req;
  int   m_addr;
  int   m_cnt;
  bit   m_err;
  int   m_code;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit known(input int ty);
    return ty >= T_I && ty <= T_JALR;
  endfunction

  function automatic bit in_range(input req_t r);
    if (r.ty == T_I || r.ty == T_S || r.ty == T_JALR) return r.imm < 32'd4096;
    if (r.ty == T_SB)  return r.imm < 32'd8192 && r.imm % 2 == 0;
    if (r.ty == T_U)   return r.imm % 4096 == 0;
    if (r.ty == T_JAL) return r.imm < 32'h0020_0000 && r.imm % 2 == 0;
    return 1'b0;
  endfunction

  // Fields a word of this type should carry, with truncation applied.
  function automatic logic [56:0] sig_req(input req_t r);
    logic [31:0] im = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  f3 = '0;
    if (r.ty == T_I || r.ty == T_JALR) begin
      im = r.imm % 4096; rd = r.rd; rs1 = r.rs1; f3 = r.f3;
    end else if (r.ty == T_S) begin
      im = r.imm % 4096; rs1 = r.rs1; rs2 = r.rs2; f3 = r.f3;
    end else if (r.ty == T_SB) begin
      im = (r.imm % 8192) & ~32'd1; rs1 = r.rs1; rs2 = r.rs2; f3 = r.f3;
    end else if (r.ty == T_U) begin
      im = r.imm & ~32'hFFF; rd = r.rd;
    end else if (r.ty == T_JAL) begin
      im = (r.imm % 32'h0020_0000) & ~32'd1; rd = r.rd;
    end
    return {im, r.op, rd, rs1, rs2, f3};
  endfunction

  // Standard RV32 decode (zero-extended immediates) of an observed word.
  function automatic logic [56:0] sig_word(input int ty, input logic [31:0] w);
    logic [31:0] im = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  f3 = '0;
    if (ty == T_I || ty == T_JALR) begin
      im = {20'b0, w[31:20]}; rd = w[11:7]; rs1 = w[19:15]; f3 = w[14:12];
    end else if (ty == T_S) begin
      im = {20'b0, w[31:25], w[11:7]}; rs1 = w[19:15]; rs2 = w[24:20]; f3 = w[14:12];
    end else if (ty == T_SB) begin
      im = {19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0};
      rs1 = w[19:15]; rs2 = w[24:20]; f3 = w[14:12];
    end else if (ty == T_U) begin
      im = {w[31:12], 12'b0}; rd = w[11:7];
    end else if (ty == T_JAL) begin
      im = {11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0}; rd = w[11:7];
    end
    return {im, w[6:0], rd, rs1, rs2, f3};
  endfunction

  task automatic set_req(input int ty, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_type   = `INST_TYPE_WIDTH'(ty);
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_imm    = imm;
  endtask

  // Compare DUT against the model mid-cycle, then advance the model across the edge.
  task automatic cycle();
    req_t cur;
    bit   rdy, acc, wacc;
    @(negedge clk);
    check("mem_we", bus.mem_we, m_we);
    if (m_we) check("word", sig_word(m_req.ty, bus.mem_wdata), sig_req(m_req));
    check("mem_addr", bus.mem_addr, m_addr);
    check("word_count", bus.word_count, m_cnt);
    check("err_valid", bus.err_valid, m_err);
    check("err_code", bus.err_code, m_code);
    check("in_ready", bus.in_ready, !m_we || bus.mem_ready);

    cur.ty  = int'(bus.in_type);
    cur.op  = bus.in_opcode;
    cur.rd  = bus.in_rd;
    cur.rs1 = bus.in_rs1;
    cur.rs2 = bus.in_rs2;
    cur.f3  = bus.in_funct3;
    cur.imm = bus.in_imm;
    rdy  = !m_we || bus.mem_ready;
    acc  = bus.in_valid && rdy;
    wacc = m_we && bus.mem_ready;
    if (!rst_n) begin
      m_we = 0; m_addr = 0; m_cnt = 0; m_err = 0; m_code = 0;
    end else begin
      m_err = 0;
      if (wacc) m_we = 0;
      if (acc) begin
        if (!known(cur.ty)) begin
          m_err = 1; m_code = 2;
        end else if (CHK && !in_range(cur)) begin
          m_err = 1; m_code = 1;
        end else begin
          m_we = 1; m_req = cur;
        end
      end
      if (bus.addr_load) begin
        m_addr = int'(bus.load_addr); m_cnt = 0;
      end else if (wacc) begin
        m_addr = (m_addr + 1) % N;
        if (m_cnt < N - 1) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.addr_load = 1'b0;
    bus.load_addr = '0;
    bus.mem_ready = 1'b1;
    set_req(T_I, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    m_we = 0; m_addr = 0; m_cnt = 0; m_err = 0; m_code = 0;
    m_req = '{ty: T_I, op: 7'h0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, imm: 32'd0};

    // Reset state
    cycle();
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_addr", bus.mem_addr, 4'd0);
    check("rst_count", bus.word_count, 4'd0);
    check("rst_err_valid", bus.err_valid, 1'b0);
    check("rst_err_code", bus.err_code, 2'd0);
    rst_n = 1'b1;

    // addi x1, x0, 5
    set_req(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    cycle();
    bus.in_valid = 1'b0;
    check("addi_we", bus.mem_we, 1'b1);
    check("addi_word", bus.mem_wdata, 32'h0050_0093);
    check("addi_addr", bus.mem_addr, 4'd0);
    cycle();
    check("addi_count", bus.word_count, 4'd1);

    // sw then beq back to back from address 0
    bus.addr_load = 1'b1;
    bus.load_addr = 4'd0;
    cycle();
    bus.addr_load = 1'b0;
    set_req(T_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    check("sw_ready", bus.in_ready, 1'b1);
    cycle();
    check("sw_word", bus.mem_wdata, 32'h0020_A423);
    check("sw_addr", bus.mem_addr, 4'd0);
    set_req(T_SB, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd16);
    check("beq_ready", bus.in_ready, 1'b1);
    cycle();
    check("beq_word", bus.mem_wdata, 32'h0020_8863);
    check("beq_addr", bus.mem_addr, 4'd1);
    bus.in_valid = 1'b0;
    cycle();
    check("sb_count", bus.word_count, 4'd2);

    // lui then jal under backpressure
    bus.mem_ready = 1'b0;
    set_req(T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    cycle();
    set_req(T_JAL, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", bus.in_ready, 1'b0);
      check("lui_word", bus.mem_wdata, 32'h1234_52B7);
      cycle();
    end
    bus.mem_ready = 1'b1;
    cycle();
    check("jal_word", bus.mem_wdata, 32'h0010_00EF);
    check("jal_addr", bus.mem_addr, 4'd3);
    bus.in_valid = 1'b0;
    cycle();

    // SB with an odd immediate
    set_req(T_SB, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    cycle();
    bus.in_valid = 1'b0;
`ifdef ASM_IMM_CHECK_EN
    check("range_err_valid", bus.err_valid, 1'b1);
    check("range_err_code", bus.err_code, 2'd1);
    check("range_no_write", bus.mem_we, 1'b0);
    cycle();
    check("range_err_drop", bus.err_valid, 1'b0);
    check("range_code_hold", bus.err_code, 2'd1);
    check("range_addr", bus.mem_addr, 4'd4);
`else
    check("trunc_we", bus.mem_we, 1'b1);
    check("trunc_word", bus.mem_wdata, 32'h0020_8163);
    check("trunc_err", bus.err_valid, 1'b0);
    cycle();
    check("trunc_addr", bus.mem_addr, 4'd5);
`endif

    // Unknown type, also out of range: type error wins
    set_req(7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 32'hFFFF_FFFF);
    cycle();
    bus.in_valid = 1'b0;
    check("type_err_valid", bus.err_valid, 1'b1);
    check("type_err_code", bus.err_code, 2'd2);
    check("type_no_write", bus.mem_we, 1'b0);
    cycle();
    check("type_err_drop", bus.err_valid, 1'b0);
    check("type_code_hold", bus.err_code, 2'd2);

    // Address wrap from all-ones
    bus.addr_load = 1'b1;
    bus.load_addr = 4'hF;
    cycle();
    bus.addr_load = 1'b0;
    set_req(T_I, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 32'd7);
    cycle();
    check("wrap_addr0", bus.mem_addr, 4'hF);
    set_req(T_I, 7'h13, 5'd3, 5'd2, 5'd0, 3'd0, 32'd9);
    cycle();
    check("wrap_addr1", bus.mem_addr, 4'h0);
    check("wrap_word1", bus.mem_wdata, 32'h0091_0193);
    bus.in_valid = 1'b0;
    cycle();
    check("wrap_addr2", bus.mem_addr, 4'h1);

    // addr_load on a write-accept edge
    bus.mem_ready = 1'b0;
    set_req(T_I, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd1);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    bus.mem_ready = 1'b1;
    bus.addr_load = 1'b1;
    bus.load_addr = 4'd5;
    cycle();
    bus.addr_load = 1'b0;
    check("load_wa_addr", bus.mem_addr, 4'd5);
    check("load_wa_count", bus.word_count, 4'd0);
    check("load_wa_we", bus.mem_we, 1'b0);

    // addr_load retargets a pending word
    bus.mem_ready = 1'b0;
    set_req(T_U, 7'h17, 5'd6, 5'd0, 5'd0, 3'd0, 32'hABCD_E000);
    cycle();
    bus.in_valid = 1'b0;
    bus.addr_load = 1'b1;
    bus.load_addr = 4'd9;
    cycle();
    bus.addr_load = 1'b0;
    check("retarget_addr", bus.mem_addr, 4'd9);
    check("retarget_we", bus.mem_we, 1'b1);
    bus.mem_ready = 1'b1;
    cycle();
    check("retarget_next", bus.mem_addr, 4'd10);
    check("retarget_count", bus.word_count, 4'd1);

    // Reset glitch between edges, then a real reset with a word pending
    bus.mem_ready = 1'b0;
    set_req(T_I, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 32'd2);
    cycle();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cycle();
    check("glitch_we", bus.mem_we, 1'b1);
    check("glitch_addr", bus.mem_addr, 4'd10);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("reset_we", bus.mem_we, 1'b0);
    check("reset_addr", bus.mem_addr, 4'd0);
    check("reset_count", bus.word_count, 4'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] imm;
      int          ty;
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      bus.addr_load = ($urandom_range(0, 80) == 0);
      bus.load_addr = AW'($urandom);
      rst_n         = ($urandom_range(0, 300) != 0);
      ty = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(T_I, T_JALR);
      imm = $urandom;
      case ($urandom_range(0, 4))
        0: imm = imm;
        1: imm = imm & 32'h0000_0FFF;
        2: imm = imm & 32'h0000_1FFE;
        3: imm = imm & 32'hFFFF_F000;
        default: imm = imm & 32'h001F_FFFE;
      endcase
      set_req(ty, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      cycle();
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    bus.addr_load = 1'b0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_assembler.md
Name: instruction_assembler

Overview:
- Inverse of the immediate decoder: packs type, opcode, register fields and an immediate into a 32-bit RV32 instruction word.
- Streams assembled words into instruction memory through a write port with backpressure and an auto-incrementing word address.
- Used by the boot/debug loader and by testbenches to build program images in-system.
- Immediate convention matches the core's decoder (zero-extended fields), so decode(encode(x)) == x for every legal x of the I, S, SB, U and JAL types.

Parameters:
ADDR_WIDTH, 10, width of the word address to instruction memory.
BASE_ADDR, 0, word address loaded at reset.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
addr_load  in  1  pulse: set write address to load_addr and clear word_count
load_addr  in  ADDR_WIDTH  new write address
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_type  in  `INST_TYPE_WIDTH  one of `INST_TYPE_I/S/SB/U/JAL/JALR
in_opcode  in  7  opcode field
in_rd, in_rs1, in_rs2  in  5 each  register fields
in_funct3  in  3  funct3 field
in_imm  in  `DATA_WIDTH  immediate value (byte offset for SB/JAL)
mem_we  out  1  write request valid
mem_ready  in  1  write accepted when mem_we && mem_ready
mem_addr  out  ADDR_WIDTH  word address
mem_wdata  out  `INST_WIDTH  assembled instruction
err_valid  out  1  one-cycle error pulse
err_code  out  2  1 = immediate out of range, 2 = unknown type
word_count  out  ADDR_WIDTH  words written since reset/addr_load; saturates at all-ones

Behaviour:
Reset (rst_n low at a clk edge):
- mem_we=0, mem_wdata=0, mem_addr=BASE_ADDR, err_valid=0, err_code=0, word_count=0.
- Any pending word is dropped.

Encoding (combinational on the inputs, registered at acceptance):
- I, JALR: {imm[11:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- U: {imm[31:12], rd, opcode}.
- JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Fields not used by a format are ignored.

Pipeline (one output register):
- in_ready = !mem_we || mem_ready.
- Accept at edge N with a legal request: from cycle N+1, mem_we=1 and mem_wdata holds the word; it stays stable until the write is accepted.
- Write accepted (mem_we && mem_ready) with no new accept: mem_we=0 next cycle.
- Accept and write-accept at the same edge: back-to-back; mem_we stays 1 with the new word, giving one word per cycle sustained throughput.

Errors:
- Illegal request accepted: no word is produced; mem_we remains as set by any concurrent write-accept; err_valid=1 for exactly cycle N+1 with err_code.
- Unknown type takes priority over a range error.
- err_code holds its last value after err_valid drops.

Address:
- mem_addr increments by 1 on each accepted write and wraps from 2^ADDR_WIDTH-1 to 0.
- word_count increments on each accepted write and saturates at all-ones.
- addr_load has priority over increment: if a write is accepted on the same edge, mem_addr=load_addr and word_count=0 afterwards.
- addr_load while mem_we=1: the pending word is retargeted to load_addr.

Optional Feature:
ASM_IMM_CHECK_EN
- Defined: immediate range checks are active. A request is illegal if:
  - I, S, JALR: imm[31:12] != 0.
  - SB: imm[31:13] != 0 or imm[0] != 0.
  - U: imm[11:0] != 0.
  - JAL: imm[31:21] != 0 or imm[0] != 0.
- Undefined: out-of-range bits are silently truncated and err_code 1 is never raised; the unknown-type error remains.

Test Plan:
- I: opcode 0x13, rd=1, rs1=0, funct3=0, imm=5, mem_ready=1 -> next cycle mem_we=1, mem_wdata=0x00500093, mem_addr=BASE_ADDR; word_count=1 after.
- S then SB back-to-back: sw (opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8), then beq (0x63, rs1=1, rs2=2, imm=16) -> 0x0020A423 at addr 0, then 0x00208863 at addr 1 on consecutive cycles; in_ready never drops.
- U + JAL under backpressure: lui (0x37, rd=5, imm=0x12345000), then jal (0x6F, rd=1, imm=2048); mem_ready low for 3 cycles -> 0x123452B7 held stable with in_ready=0; after release, 0x001000EF follows.
- Errors (macro defined): SB with imm=3 -> err_valid one cycle, err_code=1, no write, address unchanged. Unknown type -> err_code=2. Macro undefined, SB imm=3 -> word written with imm[0] dropped.
- Address: load_addr=2^ADDR_WIDTH-1, write 2 words -> addresses all-ones then 0. addr_load on a write-accept edge -> mem_addr=load_addr, word_count=0.
- Reset: rst_n low while mem_we=1 and mem_ready=0 -> next cycle mem_we=0, mem_addr=BASE_ADDR, word_count=0; a rst_n glitch between edges has no effect.
